// File: rtl/state_machine.sv
// Baccarat control FSM: sequences the four opening deals, applies the third-card
// rules to the datapath scores, and drives the win lights once the hand is decided.
module state_machine (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_CHECK   = 4'd5,
    ST_DEAL_P3 = 4'd6,
    ST_CHECK_D = 4'd7,
    ST_DEAL_D3 = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic natural;
  logic dealer_draws;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Out-of-range scores (10-15) land on the >=8 side and therefore count as a natural.
  always_comb begin
    natural = (pscore >= 4'd8) || (dscore >= 4'd8);
  end

  // Banker's draw table once the player has taken a third card.
  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (pcard3 != 4'd8);
      4'd4:             dealer_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             dealer_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             dealer_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:   state_d = ST_DEAL_P1;
      ST_DEAL_P1: state_d = ST_DEAL_D1;
      ST_DEAL_D1: state_d = ST_DEAL_P2;
      ST_DEAL_P2: state_d = ST_DEAL_D2;
      ST_DEAL_D2: state_d = ST_CHECK;
      ST_CHECK: begin
        if (natural) begin
          state_d = ST_DONE;
        end else if (pscore <= 4'd5) begin
          state_d = ST_DEAL_P3;
        end else if (dscore <= 4'd5) begin
          state_d = ST_DEAL_D3;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DEAL_P3: state_d = ST_CHECK_D;
      ST_CHECK_D: state_d = dealer_draws ? ST_DEAL_D3 : ST_DONE;
      ST_DEAL_D3: state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_RESET;
    endcase
  end

  always_comb begin
    load_pcard1      = (state_q == ST_DEAL_P1);
    load_dcard1      = (state_q == ST_DEAL_D1);
    load_pcard2      = (state_q == ST_DEAL_P2);
    load_dcard2      = (state_q == ST_DEAL_D2);
    load_pcard3      = (state_q == ST_DEAL_P3);
    load_dcard3      = (state_q == ST_DEAL_D3);
    player_win_light = (state_q == ST_DONE) && (pscore >= dscore);
    dealer_win_light = (state_q == ST_DONE) && (dscore >= pscore);
  end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for the baccarat control FSM; outputs are packed as
// {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, player_light, dealer_light}.
module tb_state_machine;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int total;
  int bad;

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_P1   = 8'b1000_0000;
  localparam logic [7:0] O_P2   = 8'b0100_0000;
  localparam logic [7:0] O_P3   = 8'b0010_0000;
  localparam logic [7:0] O_D1   = 8'b0001_0000;
  localparam logic [7:0] O_D2   = 8'b0000_1000;
  localparam logic [7:0] O_D3   = 8'b0000_0100;
  localparam logic [7:0] O_PW   = 8'b0000_0010;
  localparam logic [7:0] O_DW   = 8'b0000_0001;
  localparam logic [7:0] O_TIE  = 8'b0000_0011;

  state_machine dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  function automatic logic [7:0] outs();
    return {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
            load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // Resets, releases just after an edge, and clocks through the opening deal into CHECK.
  task automatic run_deal(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c);
    pscore = p;
    dscore = d;
    pcard3 = c;
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    pscore = 4'd9;
    dscore = 4'd9;
    pcard3 = 4'd0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== O_NONE) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, outs(), O_NONE);
      end
    end
  endtask

  task automatic test_deal();
    logic [7:0] exp_seq [5];
    exp_seq = '{O_P1, O_D1, O_P2, O_D2, O_NONE};
    pscore = 4'd8;
    dscore = 4'd0;
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (outs() !== exp_seq[i]) begin
        bad++;
        $display("FAIL deal_step[%0d]: got %b want %b", i, outs(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_natural();
    run_deal(4'd8, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== O_PW) begin
        bad++;
        $display("FAIL natural_done[%0d]: got %b want %b", i, outs(), O_PW);
      end
    end
    run_deal(4'd10, 4'd0, 4'd0);
    tick();
    total++;
    if (outs() !== O_PW) begin
      bad++;
      $display("FAIL natural_oob: got %b want %b", outs(), O_PW);
    end
  endtask

  task automatic test_player_draw_only();
    logic [7:0] exp_seq [4];
    exp_seq = '{O_P3, O_NONE, O_DW, O_DW};
    run_deal(4'd0, 4'd7, 4'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (outs() !== exp_seq[i]) begin
        bad++;
        $display("FAIL p_draw_d7[%0d]: got %b want %b", i, outs(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_both_draw();
    logic [7:0] exp_draw [4];
    logic [7:0] exp_stand [3];
    exp_draw  = '{O_P3, O_NONE, O_D3, O_TIE};
    exp_stand = '{O_P3, O_NONE, O_TIE};
    run_deal(4'd3, 4'd3, 4'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (outs() !== exp_draw[i]) begin
        bad++;
        $display("FAIL d3_pc7[%0d]: got %b want %b", i, outs(), exp_draw[i]);
      end
    end
    run_deal(4'd3, 4'd3, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== exp_stand[i]) begin
        bad++;
        $display("FAIL d3_pc8[%0d]: got %b want %b", i, outs(), exp_stand[i]);
      end
    end
  endtask

  // Edges of the banker table: {dscore, pcard3, expect_draw}.
  task automatic test_draw_table();
    logic [8:0] vec [8];
    logic [7:0] want;
    vec = '{{4'd2, 4'd8, 1'b1}, {4'd4, 4'd1, 1'b0}, {4'd4, 4'd2, 1'b1},
            {4'd4, 4'd8, 1'b0}, {4'd5, 4'd3, 1'b0}, {4'd5, 4'd4, 1'b1},
            {4'd6, 4'd6, 1'b1}, {4'd7, 4'd6, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      run_deal(4'd0, vec[i][8:5], vec[i][4:1]);
      tick();
      tick();
      tick();
      want = vec[i][0] ? O_D3 : O_DW;
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL draw_table[%0d] d=%0d c=%0d: got %b want %b",
                 i, vec[i][8:5], vec[i][4:1], outs(), want);
      end
    end
  endtask

  task automatic test_player_stands();
    run_deal(4'd6, 4'd5, 4'd0);
    tick();
    total++;
    if (outs() !== O_D3) begin
      bad++;
      $display("FAIL stand_d5_draw: got %b want %b", outs(), O_D3);
    end
    tick();
    total++;
    if (outs() !== O_PW) begin
      bad++;
      $display("FAIL stand_d5_done: got %b want %b", outs(), O_PW);
    end
    run_deal(4'd7, 4'd6, 4'd0);
    tick();
    total++;
    if (outs() !== O_PW) begin
      bad++;
      $display("FAIL stand_d6_done: got %b want %b", outs(), O_PW);
    end
    run_deal(4'd6, 4'd6, 4'd0);
    tick();
    total++;
    if (outs() !== O_TIE) begin
      bad++;
      $display("FAIL stand_tie: got %b want %b", outs(), O_TIE);
    end
  endtask

  task automatic test_mid_reset();
    pscore = 4'd8;
    dscore = 4'd0;
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    tick();
    tick();
    total++;
    if (outs() !== O_D1) begin
      bad++;
      $display("FAIL mid_pre: got %b want %b", outs(), O_D1);
    end
    #2;
    resetb = 1'b0;
    #1;
    total++;
    if (outs() !== O_NONE) begin
      bad++;
      $display("FAIL mid_async: got %b want %b", outs(), O_NONE);
    end
    tick();
    tick();
    total++;
    if (outs() !== O_NONE) begin
      bad++;
      $display("FAIL mid_hold: got %b want %b", outs(), O_NONE);
    end
    resetb = 1'b1;
    tick();
    total++;
    if (outs() !== O_P1) begin
      bad++;
      $display("FAIL mid_restart: got %b want %b", outs(), O_P1);
    end
    tick();
    total++;
    if (outs() !== O_D1) begin
      bad++;
      $display("FAIL mid_restart_d1: got %b want %b", outs(), O_D1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_deal();
    test_natural();
    test_player_draw_only();
    test_both_draw();
    test_draw_table();
    test_player_stands();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
